// File: rtl/vec_wb_collector_pkg.sv
// vec_wb_collector_pkg: FSM states, element-width codes and beat-width helper for the writeback collector
package vec_wb_collector_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
  localparam logic [2:0] SEW8 = 3'b000, SEW16 = 3'b001, SEW32 = 3'b010, SEW64 = 3'b011;
  function automatic int beat_w(input logic [2:0] vsew, input int lw);
    int e;
    int c;
    e = vsew == SEW8 ? 8 : vsew == SEW16 ? 16 : vsew == SEW32 ? 32 : 64;
    c = 1 << lw;
    return e < c ? e : c;
  endfunction
endpackage

// File: rtl/vec_wb_lane_mask.sv
// vec_wb_lane_mask: decodes log2 lane count into an active-lane mask, clamping 3 to 2
module vec_wb_lane_mask (
  input  logic [1:0] nb_lanes,
  output logic [3:0] mask
);
  always_comb mask = nb_lanes == 2'd0 ? 4'b0001 : nb_lanes == 2'd1 ? 4'b0011 : 4'b1111;
endmodule

// File: rtl/vec_wb_collector.sv
// vec_wb_collector: gathers per-lane result beats into one vector register and hands it to the register file
module vec_wb_collector
  import vec_wb_collector_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      vsew,
  input  logic [1:0]      nb_lanes,
  input  logic [3:0]      lane_valid,
  input  logic [63:0]     vd0,
  input  logic [63:0]     vd1,
  input  logic [63:0]     vd2,
  input  logic [63:0]     vd3,
  input  logic [9:0]      regi0,
  input  logic [9:0]      regi1,
  input  logic [9:0]      regi2,
  input  logic [9:0]      regi3,
  input  logic [3:0]      lane_done,
  input  logic            wb_ready,
  output logic            wb_valid,
  output logic [VLEN-1:0] wb_data,
  output logic            busy,
  output logic            err
);
  state_t          state;
  logic [2:0]      vsew_q;
  logic [1:0]      nb_q;
  logic [3:0]      act;
  logic [VLEN-1:0] acc, acc_nxt, m;
  logic [63:0]     vd [4];
  logic [9:0]      regi [4];
  logic [63:0]     bm;
  logic            err_nxt;
  int              w;
  assign vd[0] = vd0;
  assign vd[1] = vd1;
  assign vd[2] = vd2;
  assign vd[3] = vd3;
  assign regi[0] = regi0;
  assign regi[1] = regi1;
  assign regi[2] = regi2;
  assign regi[3] = regi3;
  assign wb_data = acc;
  vec_wb_lane_mask u_mask (.nb_lanes(nb_q), .mask(act));
  // Lanes are merged in ascending order so the highest-numbered lane wins on overlap.
  always_comb begin
    acc_nxt = acc;
    err_nxt = err;
    m = '0;
    w = beat_w(vsew_q, LANE_WIDTH);
    bm = {64{1'b1}} >> (64 - w);
    for (int i = 0; i < 4; i++)
      if (act[i] && lane_valid[i]) begin
        if (int'(regi[i]) + w > VLEN) err_nxt = 1'b1;
        else begin
          m = VLEN'(bm) << regi[i];
          acc_nxt = (acc_nxt & ~m) | (VLEN'(vd[i] & bm) << regi[i]);
        end
      end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      err <= 1'b0;
      wb_valid <= 1'b0;
      busy <= 1'b0;
      vsew_q <= '0;
      nb_q <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= COLLECT;
          busy <= 1'b1;
          acc <= '0;
          err <= 1'b0;
          vsew_q <= vsew;
          nb_q <= nb_lanes;
        end
        COLLECT: begin
          acc <= acc_nxt;
          err <= err_nxt;
          if ((lane_done & act) == act) begin
            state <= WRITE;
            wb_valid <= 1'b1;
          end
        end
        WRITE: if (wb_ready) begin
          state <= IDLE;
          wb_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_vec_wb_collector.sv
// tb_vec_wb_collector: directed and randomized checks of the collector against a bit-level reference model
module tb_vec_wb_collector;
  logic         clk = 1'b0;
  logic         reset, start, wb_ready, wb_valid, busy, err;
  logic [2:0]   vsew;
  logic [1:0]   nb_lanes;
  logic [3:0]   lane_valid, lane_done;
  logic [63:0]  vd [4];
  logic [9:0]   regi [4];
  logic [127:0] wb_data, exp_acc;
  logic         exp_err;
  int           exp_w, exp_n;
  int           n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  vec_wb_collector dut (
    .clk(clk), .reset(reset), .start(start), .vsew(vsew), .nb_lanes(nb_lanes),
    .lane_valid(lane_valid), .vd0(vd[0]), .vd1(vd[1]), .vd2(vd[2]), .vd3(vd[3]),
    .regi0(regi[0]), .regi1(regi[1]), .regi2(regi[2]), .regi3(regi[3]),
    .lane_done(lane_done), .wb_ready(wb_ready), .wb_valid(wb_valid),
    .wb_data(wb_data), .busy(busy), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_instr(input logic [2:0] vs, input logic [1:0] nb);
    vsew = vs;
    nb_lanes = nb;
    start = 1'b1;
    tick();
    start = 1'b0;
    vsew = 3'($urandom_range(0, 3));
    nb_lanes = 2'($urandom);
    exp_acc = '0;
    exp_err = 1'b0;
    exp_w = (8 << vs) < 16 ? (8 << vs) : 16;
    exp_n = 1 << (nb > 2 ? 2 : nb);
  endtask

  // One COLLECT cycle; the model writes bits one at a time, lanes in order.
  task automatic beat(input logic [3:0] lv, input logic [3:0] ld, input bit junk_start);
    lane_valid = lv;
    lane_done = ld;
    start = junk_start;
    for (int i = 0; i < 4; i++)
      if (lv[i] && i < exp_n) begin
        if (int'(regi[i]) + exp_w > 128) exp_err = 1'b1;
        else for (int b = 0; b < exp_w; b++) exp_acc[int'(regi[i]) + b] = vd[i][b];
      end
    tick();
    lane_valid = '0;
    lane_done = '0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    vsew = '0;
    nb_lanes = '0;
    lane_valid = 4'hF;
    lane_done = 4'hF;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vd[i] = {$urandom, $urandom};
      regi[i] = '0;
    end
    tick();
    tick();
    n_vec++;
    if ({wb_valid, busy, err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000", {wb_valid, busy, err});
    end
    n_vec++;
    if (wb_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", wb_data);
    end
    reset = 1'b0;
    start = 1'b0;
    lane_valid = '0;
    lane_done = '0;
    wb_ready = 1'b0;
    tick();
  endtask

  task automatic test_add_vv;
    logic [127:0] c = 128'h3232eeeed0231467d02314673232eeee;
    int idx;
    start_instr(3'b000, 2'd2);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        idx = (4 * k + i) % 16;
        vd[i] = {56'($urandom), c[8*idx +: 8]};
        regi[i] = 10'(8 * idx);
      end
      beat(4'hF, k == 7 ? 4'hF : 4'h0, 1'b0);
    end
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== c) begin
      n_err++;
      $display("FAIL add_vv: got v=%b %h want v=1 %h", wb_valid, wb_data, c);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    n_vec++;
    if ({wb_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL add_vv_done: got %b want 00", {wb_valid, busy});
    end
  endtask

  task automatic test_latency;
    logic [127:0] c = 128'h3332eeeed1241567d12415673332eeee;
    start_instr(3'b010, 2'd0);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        vd[i] = {$urandom, $urandom};
        regi[i] = '0;
      end
      vd[0][15:0] = c[16*k +: 16];
      regi[0] = 10'(16 * k);
      if (k == 7) begin
        beat(4'h0, 4'b1110, 1'b0);
        n_vec++;
        if (wb_valid !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL inactive_done: got v=%b busy=%b want v=0 busy=1", wb_valid, busy);
        end
      end
      beat(4'hF, k == 7 ? 4'b0001 : 4'b0000, 1'b0);
      if (k == 6) begin
        n_vec++;
        if (wb_valid !== 1'b0) begin
          n_err++;
          $display("FAIL early_valid: got %b want 0", wb_valid);
        end
      end
    end
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== c) begin
      n_err++;
      $display("FAIL latency: got v=%b %h want v=1 %h", wb_valid, wb_data, c);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_ready_stall;
    logic [127:0] held;
    start_instr(3'b001, 2'd1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        vd[i] = {$urandom, $urandom};
        regi[i] = 10'($urandom_range(0, 112));
      end
      beat(4'($urandom), k == 2 ? 4'b0011 : 4'b0000, 1'b0);
    end
    held = exp_acc;
    for (int c = 0; c < 5; c++) begin
      lane_valid = 4'hF;
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        vd[i] = {$urandom, $urandom};
        regi[i] = '0;
      end
      n_vec++;
      if (wb_valid !== 1'b1 || wb_data !== held) begin
        n_err++;
        $display("FAIL stall_%0d: got v=%b %h want v=1 %h", c, wb_valid, wb_data, held);
      end
      tick();
    end
    lane_valid = '0;
    start = 1'b0;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    n_vec++;
    if ({wb_valid, busy} !== 2'b00 || wb_data !== held) begin
      n_err++;
      $display("FAIL stall_release: got v=%b busy=%b %h want 00 %h", wb_valid, busy, wb_data, held);
    end
  endtask

  task automatic test_err;
    start_instr(3'b001, 2'd0);
    vd[0] = {$urandom, $urandom};
    regi[0] = 10'd112;
    beat(4'b0001, 4'b0000, 1'b0);
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_edge_fit: got %b want 0", err);
    end
    vd[0] = {$urandom, $urandom};
    regi[0] = 10'd120;
    beat(4'b0001, 4'b0001, 1'b0);
    n_vec++;
    if (err !== 1'b1 || exp_err !== 1'b1 || wb_data !== exp_acc) begin
      n_err++;
      $display("FAIL err_drop: got err=%b %h want err=1 %h", err, wb_data, exp_acc);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    start_instr(3'b000, 2'd0);
    n_vec++;
    if (err !== 1'b0 || wb_data !== '0) begin
      n_err++;
      $display("FAIL err_clear: got err=%b %h want err=0 0", err, wb_data);
    end
    beat(4'b0000, 4'b0001, 1'b0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_overlap;
    logic [15:0] lo;
    start_instr(3'b001, 2'd2);
    for (int i = 0; i < 4; i++) begin
      vd[i] = {$urandom, $urandom};
      regi[i] = 10'd64;
    end
    vd[1][15:0] = 16'h1111;
    vd[3][15:0] = 16'h3333;
    regi[1] = '0;
    regi[3] = '0;
    beat(4'b1010, 4'hF, 1'b0);
    lo = wb_data[15:0];
    n_vec++;
    if (lo !== 16'h3333 || wb_data !== exp_acc) begin
      n_err++;
      $display("FAIL overlap: got %h want %h (low 3333)", wb_data, exp_acc);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    start_instr(3'b000, 2'd2);
    for (int i = 0; i < 4; i++) begin
      vd[i] = {$urandom, $urandom};
      regi[i] = 10'(8 * i);
    end
    beat(4'hF, 4'h0, 1'b0);
    reset = 1'b1;
    lane_valid = 4'hF;
    lane_done = 4'hF;
    wb_ready = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({wb_valid, busy, err} !== 3'b000 || wb_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b busy=%b err=%b %h want 000 0", wb_valid, busy, err, wb_data);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wb_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL reset_mid_pulse: got wb_valid pulse want none");
    end
    lane_valid = '0;
    lane_done = '0;
    wb_ready = 1'b0;
  endtask

  task automatic test_random;
    int nbeats;
    logic [3:0] amask;
    for (int t = 0; t < 30; t++) begin
      lane_valid = 4'hF;
      for (int i = 0; i < 4; i++) begin
        vd[i] = {$urandom, $urandom};
        regi[i] = '0;
      end
      tick();
      lane_valid = '0;
      n_vec++;
      if (wb_data !== exp_acc || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_idle_%0d: got busy=%b %h want busy=0 %h", t, busy, wb_data, exp_acc);
      end
      start_instr(3'($urandom_range(0, 3)), 2'($urandom));
      amask = 4'((1 << exp_n) - 1);
      nbeats = $urandom_range(1, 6);
      for (int k = 0; k < nbeats; k++) begin
        for (int i = 0; i < 4; i++) begin
          vd[i] = {$urandom, $urandom};
          regi[i] = 10'($urandom_range(0, 135));
        end
        beat(4'($urandom), k == nbeats - 1 ? (4'($urandom) | amask) : (4'($urandom) & ~amask),
             $urandom_range(0, 3) == 0);
      end
      for (int d = $urandom_range(0, 3); d > 0; d--) begin
        n_vec++;
        if (wb_valid !== 1'b1 || wb_data !== exp_acc || err !== exp_err) begin
          n_err++;
          $display("FAIL rnd_%0d: got v=%b err=%b %h want v=1 err=%b %h",
                   t, wb_valid, err, wb_data, exp_err, exp_acc);
        end
        tick();
      end
      n_vec++;
      if (wb_valid !== 1'b1 || wb_data !== exp_acc || err !== exp_err) begin
        n_err++;
        $display("FAIL rnd_final_%0d: got v=%b err=%b %h want v=1 err=%b %h",
                 t, wb_valid, err, wb_data, exp_err, exp_acc);
      end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      n_vec++;
      if ({wb_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL rnd_done_%0d: got %b want 00", t, {wb_valid, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_vv();
    test_latency();
    test_ready_stall();
    test_err();
    test_overlap();
    test_reset_mid();
    exp_acc = '0;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vec_wb_collector.md
VEC_WB_COLLECTOR -- requirements
Module: vec_wb_collector

Interface
REQ-001 Parameter VLEN, default 10'd128: vector register length in bits.
REQ-002 Parameter LANE_WIDTH, default 3'b100: log2 of lane datapath width in bits (16).
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port start  input  1: one-cycle pulse opening a new instruction; vsew and nb_lanes are sampled on this cycle.
REQ-006 Port vsew  input  3: element width code, 000=8b … 011=64b.
REQ-007 Port nb_lanes  input  2: log2 of active lane count; 3 is clamped to 2.
REQ-008 Port lane_valid  input  4: per-lane result strobe, bit i qualifies vd<i>/regi<i>.
REQ-009 Ports vd0..vd3  input  64 each: lane results, data in the low bits.
REQ-010 Ports regi0..regi3  input  10 each: bit offset of each lane result inside the destination register.
REQ-011 Port lane_done  input  4: per-lane level, high once that lane has issued its last result.
REQ-012 Port wb_ready  input  1: register-file write acceptance.
REQ-013 Port wb_valid  output  1: assembled register is available.
REQ-014 Port wb_data  output  VLEN: assembled destination register.
REQ-015 Port busy  output  1: high while in COLLECT or WRITE.
REQ-016 Port err  output  1: sticky out-of-range flag, cleared by start.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, COLLECT and WRITE.
- IDLE -> COLLECT on start.
- COLLECT -> WRITE on the first cycle all active lanes have lane_done high.
- WRITE -> IDLE on the cycle wb_valid and wb_ready are both high.
REQ-018 On start, the accumulator SHALL clear to 0 and err SHALL clear; the latched vsew/nb_lanes SHALL apply to the whole instruction.
REQ-019 Beat width SHALL be W = min(8<<vsew, 1<<LANE_WIDTH) bits.
REQ-020 In COLLECT, for each active lane i with lane_valid[i], the accumulator bits [regi<i> +: W] SHALL take vd<i>[W-1:0] at the next edge.
REQ-021 Lane i SHALL be active iff i < (1 << min(nb_lanes,2)); lane_valid of inactive lanes SHALL be ignored.
REQ-022 On simultaneous writes to overlapping bits, the highest-numbered lane SHALL win.
REQ-023 If regi<i> + W > VLEN, that write SHALL be dropped and err SHALL set.
REQ-024 A beat presented in the same cycle as the final lane_done SHALL be captured before wb_data is exposed.
REQ-025 wb_valid SHALL be high only in WRITE, and wb_data SHALL be stable while wb_valid is high and wb_ready is low.
REQ-026 lane_valid SHALL be ignored outside COLLECT.
REQ-027 start SHALL be ignored while busy.
REQ-028 Latency SHALL be one cycle: wb_valid rises the cycle after the final lane_done is observed.
REQ-029 wb_data SHALL equal the accumulator; bits never written SHALL read 0.

Reset
REQ-030 While reset is high, the FSM SHALL go to IDLE, the accumulator and wb_data SHALL be 0, and wb_valid, busy and err SHALL be 0.
REQ-031 Reset SHALL take priority over start and wb_ready; reset mid-COLLECT or mid-WRITE SHALL abort with no write issued.

Structure
REQ-032 The shared vector package SHALL hold the FSM state encoding, the vsew codes and the beat-width function min(8<<vsew, 1<<LANE_WIDTH).
REQ-033 A sub-module vec_wb_lane_mask SHALL decode nb_lanes into the active-lane mask; all other logic is flat.

Verification
REQ-034 nb_lanes=2, vsew=000, 8 beats/lane of add.vv results -> single wb_valid with wb_data=128'h3232eeeed0231467d02314673232eeee.
REQ-035 nb_lanes=0, vsew=010, 8 beats of W=16 at regi 0,16,…,112 -> wb_data=128'h3332eeeed1241567d12415673332eeee; wb_valid appears 1 cycle after lane_done.
REQ-036 wb_ready held low for 5 cycles in WRITE -> wb_valid and wb_data unchanged; transition to IDLE exactly on the ready cycle.
REQ-037 regi0=10'd120, vsew=001 (W=16) -> write dropped, err=1, accumulator unchanged; the next start clears err.
REQ-038 Lanes 1 and 3 write regi=0 in the same cycle with vd1=16'h1111 and vd3=16'h3333 -> wb_data[15:0]=16'h3333.
REQ-039 reset asserted mid-COLLECT -> next cycle state IDLE, busy=0, wb_data=0, no wb_valid pulse.
